alu_wide_sequencer: RTL and testbench

Multi-precision front end for the 8-bit ALU. It accepts wide operations (BYTES×8 bits) over a valid/ready handshake and issues them to the ALU one byte per cycle, least-significant byte first. For add and subtract it chains the ALU carry/borrow between bytes. It collects the result bytes and presents the wide result, carry and zero flag downstream over a second valid/ready handshake.

---
 rtl/alu_wide_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_wide_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// Multi-precision front end for an 8-bit combinational ALU: accepts a wide op,
// issues it one byte per cycle (LSB first), and returns the wide result.
module alu_wide_sequencer #(
  parameter int unsigned BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   in_a,
  input  logic [8*BYTES-1:0]   in_b,
  input  logic                 in_c_in,
  input  logic [2:0]           in_control_line,
  input  logic                 in_mode_select,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic                 alu_c_in,
  output logic [2:0]           alu_control_line,
  output logic                 alu_mode_select,
  input  logic [7:0]           alu_out,
  input  logic                 alu_c_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*BYTES-1:0]   res_data,
  output logic                 res_c_out,
  output logic                 res_zero
);

  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  generate
    if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
      $error("alu_wide_sequencer: BYTES must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [W-1:0]     a_reg, b_reg, res_next;
  logic             c_in_reg, mode_reg, carry, chained;
  logic [2:0]       ctl_reg;
  logic [IDX_W-1:0] idx;

  // Only add/sub propagate carry between bytes; everything else is per byte.
  assign chained   = mode_reg && (ctl_reg == 3'd0 || ctl_reg == 3'd1);
  assign res_c_out = carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next       = state;
    in_ready         = 1'b0;
    res_valid        = 1'b0;
    alu_a            = '0;
    alu_b            = '0;
    alu_c_in         = 1'b0;
    alu_control_line = '0;
    alu_mode_select  = 1'b0;
    res_next         = res_data;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        alu_a            = a_reg[8*idx +: 8];
        alu_b            = b_reg[8*idx +: 8];
        alu_c_in         = chained ? carry : c_in_reg;
        alu_control_line = ctl_reg;
        alu_mode_select  = mode_reg;
        res_next[8*idx +: 8] = alu_out;
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      c_in_reg <= 1'b0;
      ctl_reg  <= '0;
      mode_reg <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      res_data <= '0;
      res_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            c_in_reg <= in_c_in;
            ctl_reg  <= in_control_line;
            mode_reg <= in_mode_select;
            idx      <= '0;
            carry    <= in_c_in;
          end
        end
        EXEC: begin
          res_data <= res_next;
          carry    <= alu_c_out;
          // Zero flag is taken from the fully assembled word on the last byte.
          if (idx == LAST) res_zero <= (res_next == '0);
          else             idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer (BYTES=4) with a behavioural ALU
// and a wide-arithmetic reference model.
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        in_c_in;
  logic [2:0]  in_control_line;
  logic        in_mode_select;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_c_in, alu_mode_select, alu_c_out;
  logic [2:0]  alu_control_line;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_c_out, res_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c_in(in_c_in),
    .in_control_line(in_control_line), .in_mode_select(in_mode_select),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_control_line(alu_control_line), .alu_mode_select(alu_mode_select),
    .alu_out(alu_out), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_c_out(res_c_out), .res_zero(res_zero)
  );

  // 8-bit ALU: {carry/borrow, result}
  function automatic logic [8:0] alu_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic c, input logic [2:0] ctl,
                                          input logic mode);
    if (mode) begin
      case (ctl)
        3'd0:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
        3'd1:    return {1'b0, a} - {1'b0, b} - {8'd0, c};
        3'd2:    return {1'b0, a} + 9'd1;
        3'd3:    return {1'b0, a} - 9'd1;
        default: return {c, a};
      endcase
    end else begin
      case (ctl)
        3'd0:    return {1'b0, a & b};
        3'd1:    return {1'b0, a | b};
        3'd2:    return {1'b0, a ^ b};
        3'd3:    return {1'b0, ~a};
        3'd4:    return {1'b0, a << 2};
        3'd5:    return {1'b0, a >> 2};
        default: return 9'd0;
      endcase
    end
  endfunction

  always_comb {alu_c_out, alu_out} = alu_byte(alu_a, alu_b, alu_c_in, alu_control_line, alu_mode_select);

  // Reference: add/sub as whole-word arithmetic, other ops byte by byte.
  task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [2:0] ctl, input logic mode,
                        output logic [31:0] r, output logic c);
    logic [32:0] t;
    logic [8:0]  t9;
    r = '0;
    c = 1'b0;
    if (mode && ctl == 3'd0) begin
      t = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r = t[31:0]; c = t[32];
    end else if (mode && ctl == 3'd1) begin
      t = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      r = t[31:0]; c = t[32];
    end else begin
      for (int i = 0; i < 4; i++) begin
        t9 = alu_byte(a[8*i +: 8], b[8*i +: 8], cin, ctl, mode);
        r[8*i +: 8] = t9[7:0];
        c = t9[8];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [2:0] ctl, input logic mode,
                        input logic [31:0] exp_d, input logic exp_c, input logic early);
    int n = 0;
    in_a = a; in_b = b; in_c_in = cin; in_control_line = ctl; in_mode_select = mode;
    in_valid = 1'b1; res_ready = 1'b0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    in_a = ~a;
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!res_valid && n < 20) begin
      res_ready = early ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk({tag, "_data"}, 64'(res_data), 64'(exp_d));
    chk({tag, "_cout"}, 64'(res_c_out), 64'(exp_c));
    chk({tag, "_zero"}, 64'(res_zero), 64'(exp_d == 32'd0));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ea, eb, ed;
    logic        ec, ecin, emode;
    logic [2:0]  ectl;

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_c_in = 1'b0; in_control_line = '0; in_mode_select = 1'b0;
    #7;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_outputs", 64'({res_data, res_c_out, res_zero}), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_b, alu_c_in, alu_control_line, alu_mode_select}), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_op("add_chain", 32'h000000FF, 32'h00000001, 1'b0, 3'd0, 1'b1, 32'h00000100, 1'b0, 1'b0);
    run_op("sub_chain", 32'h00000000, 32'h00000001, 1'b0, 3'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("add_ovf",   32'hFFFFFFFF, 32'h00000000, 1'b1, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_op("and",       32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'd0, 1'b0, 32'hF000F000, 1'b0, 1'b0);
    run_op("shl2",      32'h81818181, 32'h00000000, 1'b0, 3'd4, 1'b0, 32'h04040404, 1'b0, 1'b1);

    // Backpressure with a second op waiting upstream.
    in_a = 32'h12345678; in_b = 32'h11111111; in_c_in = 1'b0;
    in_control_line = 3'd0; in_mode_select = 1'b1; in_valid = 1'b1; res_ready = 1'b0;
    step();
    in_a = ~in_a;
    wait_result("bp1");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_data", 64'(res_data), 64'h23456789);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_a = $urandom;
      step();
    end
    in_a = 32'h10000000; in_b = 32'h00000001; in_control_line = 3'd1;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_valid_drop", 64'(res_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    wait_result("bp2");
    chk("bp2_data", 64'(res_data), 64'h0FFFFFFF);
    chk("bp2_cout", 64'(res_c_out), 64'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset two cycles into EXEC.
    in_a = 32'h01010101; in_b = 32'h02020202; in_c_in = 1'b1;
    in_control_line = 3'd0; in_mode_select = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res", 64'({res_data, res_c_out, res_zero}), 64'd0);
    chk("mid_rst_alu", 64'({alu_a, alu_b, alu_c_in, alu_control_line, alu_mode_select}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("mid_no_valid", 64'(res_valid), 64'd0);
    end
    run_op("post_rst_add", 32'h00000001, 32'h00000001, 1'b0, 3'd0, 1'b1, 32'h00000002, 1'b0, 1'b0);

    // Randomised ops checked against the reference model.
    for (int k = 0; k < 24; k++) begin
      ea = $urandom; eb = $urandom; ecin = 1'($urandom_range(0, 1));
      emode = 1'($urandom_range(0, 1)); ectl = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) begin
        emode = 1'b0; ectl = 3'd2; eb = ea;
      end
      ref_op(ea, eb, ecin, ectl, emode, ed, ec);
      run_op("rand", ea, eb, ecin, ectl, emode, ed, ec, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
